wd_sector_buffer: RTL and testbench

//  Multi-bank sector buffer between the wd1793 buff_* port and a host storage engine (SD/SPI loader).

---
 rtl/wd_sector_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_wd_sector_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wd_sector_buffer.sv
// Multi-bank sector buffer between the wd1793 buff_* port and a host storage engine.
// Optional build macro WD_SECBUF_GUARD_EN rejects controller accesses outside a held bank or past SECTOR_LEN.
module wd_sector_buffer #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int BANKS      = 2,
    parameter int SECTOR_LEN = 512,
    localparam int BW        = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] buff_addr,
    input  logic              buff_rd,
    input  logic              buff_wr,
    input  logic [DATA_W-1:0] buff_odata,
    output logic [DATA_W-1:0] buff_idata,
    input  logic              ctl_req,
    input  logic              ctl_write,
    input  logic              ctl_done,
    output logic              ctl_ready,
    output logic              ctl_err,
    output logic [BW-1:0]     host_bank,
    input  logic              host_load_en,
    input  logic              host_flush,
    output logic              flush_busy,
    input  logic              host_wvalid,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_wready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rlast,
    input  logic              host_rready
);

    localparam int CW    = (SECTOR_LEN > 1) ? $clog2(SECTOR_LEN) : 1;
    localparam int DEPTH = BANKS * (2 ** ADDR_W);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(SECTOR_LEN - 1);

    typedef enum logic [2:0] {FREE, LOADING, READY, HELD, DIRTY, STORING} bank_state_t;

    bank_state_t       st [BANKS];
    logic [DATA_W-1:0] mem [DEPTH];
    logic [BW-1:0]     cp, hp;
    logic              pend, pend_write, held_write, flush_pend;
    logic [CW-1:0]     host_cnt, issue_cnt;
    logic              issue_done, inflight, out_vld, skid_vld;
    logic [DATA_W-1:0] out_data, skid_data, rd_data_b;

    logic              access_ok, accept, grant, load_start, ld_fire, pop, issue, flush_go;
    logic [1:0]        occ;
    logic [AW-1:0]     a_addr, b_addr;

    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == BW'(BANKS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign a_addr = AW'({cp, buff_addr});
    assign b_addr = AW'({hp, (st[hp] == LOADING) ? ADDR_W'(host_cnt) : ADDR_W'(issue_cnt)});

`ifdef WD_SECBUF_GUARD_EN
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(SECTOR_LEN);
    assign access_ok = ctl_ready && ({1'b0, buff_addr} < LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_err <= 1'b0;
        end else begin
            if (accept)
                ctl_err <= 1'b0;
            if ((buff_wr || buff_rd) && !access_ok)
                ctl_err <= 1'b1;
        end
    end
`else
    assign access_ok = 1'b1;
    assign ctl_err   = 1'b0;
`endif

    // A same-cycle ctl_done frees the held slot, so the new request can be latched.
    assign accept     = ctl_req && !pend && (!ctl_ready || ctl_done);
    assign grant      = pend && !ctl_ready &&
                        ((st[cp] == READY) || (pend_write && st[cp] == FREE));
    assign load_start = (st[hp] == FREE) && host_load_en && !flush_pend &&
                        !(grant && pend_write && cp == hp);
    assign host_wready = (st[hp] == LOADING);
    assign ld_fire     = host_wvalid && host_wready;

    // At most two bytes may be in flight between the RAM and the host (output + skid).
    assign pop   = out_vld && host_rready;
    assign occ   = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, inflight} - {1'b0, pop};
    assign issue = (st[hp] == STORING) && !issue_done && (occ < 2'd2);

    always_comb begin
        flush_go = flush_pend;
        for (int b = 0; b < BANKS; b++)
            if (st[b] == DIRTY || st[b] == STORING)
                flush_go = 1'b0;
    end

    assign host_bank   = hp;
    assign flush_busy  = flush_pend;
    assign host_rvalid = out_vld;
    assign host_rdata  = out_data;
    assign host_rlast  = out_vld && (host_cnt == LAST);

    always_ff @(posedge clk) begin
        if (buff_wr && access_ok)
            mem[a_addr] <= buff_odata;
        if (ld_fire)
            mem[b_addr] <= host_wdata;
        rd_data_b <= mem[b_addr];
    end

    always_ff @(posedge clk) begin
        if (reset)
            buff_idata <= '0;
        else if (buff_rd)
            buff_idata <= access_ok ? mem[a_addr] : '1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < BANKS; b++)
                st[b] <= FREE;
            cp         <= '0;
            hp         <= '0;
            pend       <= 1'b0;
            pend_write <= 1'b0;
            held_write <= 1'b0;
            ctl_ready  <= 1'b0;
            flush_pend <= 1'b0;
            host_cnt   <= '0;
            issue_cnt  <= '0;
            issue_done <= 1'b0;
            inflight   <= 1'b0;
            out_vld    <= 1'b0;
            skid_vld   <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
                if (issue_cnt == LAST)
                    issue_done <= 1'b1;
            end

            if (!out_vld || pop) begin
                if (skid_vld) begin
                    out_vld   <= 1'b1;
                    out_data  <= skid_data;
                    skid_vld  <= inflight;
                    skid_data <= rd_data_b;
                end else begin
                    out_vld  <= inflight;
                    out_data <= rd_data_b;
                end
            end else if (inflight) begin
                skid_vld  <= 1'b1;
                skid_data <= rd_data_b;
            end

            case (st[hp])
                DIRTY:   st[hp] <= STORING;
                FREE:    if (load_start) st[hp] <= LOADING;
                LOADING: if (ld_fire) begin
                    host_cnt <= host_cnt + 1'b1;
                    if (host_cnt == LAST) begin
                        st[hp]   <= READY;
                        hp       <= ptr_inc(hp);
                        host_cnt <= '0;
                    end
                end
                STORING: if (pop) begin
                    host_cnt <= host_cnt + 1'b1;
                    if (host_cnt == LAST) begin
                        st[hp]     <= FREE;
                        hp         <= ptr_inc(hp);
                        host_cnt   <= '0;
                        issue_cnt  <= '0;
                        issue_done <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Flush overrides host progress; controller updates below override the flush.
            if (flush_go) begin
                for (int b = 0; b < BANKS; b++)
                    if (st[b] == READY || st[b] == LOADING)
                        st[b] <= FREE;
                hp         <= cp;
                host_cnt   <= '0;
                flush_pend <= 1'b0;
            end
            if (host_flush)
                flush_pend <= 1'b1;

            if (ctl_ready && ctl_done) begin
                st[cp]    <= held_write ? DIRTY : FREE;
                cp        <= ptr_inc(cp);
                ctl_ready <= 1'b0;
            end
            if (accept) begin
                pend       <= 1'b1;
                pend_write <= ctl_write;
            end
            if (grant) begin
                st[cp]     <= HELD;
                held_write <= pend_write;
                pend       <= 1'b0;
                ctl_ready  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wd_sector_buffer.sv
// Scoreboard bench for wd_sector_buffer (BANKS=2, ADDR_W=4, SECTOR_LEN=16); honours WD_SECBUF_GUARD_EN.
module tb_wd_sector_buffer;

`ifdef WD_SECBUF_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] buff_addr;
    logic       buff_rd, buff_wr;
    logic [7:0] buff_odata, buff_idata;
    logic       ctl_req, ctl_write, ctl_done, ctl_ready, ctl_err;
    logic [0:0] host_bank;
    logic       host_load_en, host_flush, flush_busy;
    logic       host_wvalid, host_wready;
    logic [7:0] host_wdata;
    logic       host_rvalid, host_rlast, host_rready;
    logic [7:0] host_rdata;

    int total = 0;
    int passed = 0;
    int drained = 0;
    logic [7:0] rd_q[$];
    logic [8:0] drain_q[$];

    always #5 clk = ~clk;

    wd_sector_buffer #(.ADDR_W(4), .DATA_W(8), .BANKS(2), .SECTOR_LEN(16)) dut (
        .clk(clk), .reset(reset),
        .buff_addr(buff_addr), .buff_rd(buff_rd), .buff_wr(buff_wr),
        .buff_odata(buff_odata), .buff_idata(buff_idata),
        .ctl_req(ctl_req), .ctl_write(ctl_write), .ctl_done(ctl_done),
        .ctl_ready(ctl_ready), .ctl_err(ctl_err),
        .host_bank(host_bank), .host_load_en(host_load_en), .host_flush(host_flush),
        .flush_busy(flush_busy), .host_wvalid(host_wvalid), .host_wdata(host_wdata),
        .host_wready(host_wready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_rlast(host_rlast), .host_rready(host_rready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares buff_idata the cycle after each read and every accepted drain byte.
    initial begin : monitor
        logic       rd_seen;
        logic [7:0] r;
        logic [8:0] e;
        rd_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_seen) begin
                if (rd_q.size() == 0) begin
                    total++;
                    $display("FAIL rd_extra: got 0x%0h expected no read", buff_idata);
                end else begin
                    r = rd_q.pop_front();
                    check("buff_idata", 32'(buff_idata), 32'(r));
                end
            end
            rd_seen = buff_rd;
            if (host_rvalid && host_rready) begin
                if (drain_q.size() == 0) begin
                    total++;
                    $display("FAIL drain_extra: got 0x%0h expected no byte", host_rdata);
                end else begin
                    e = drain_q.pop_front();
                    check("drain_data", 32'(host_rdata), 32'(e[7:0]));
                    check("drain_last", 32'(host_rlast), 32'(e[8]));
                end
                drained++;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic fill(input logic [7:0] base, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (host_wready !== 1'b1 && w < 50) begin tick(); w++; end
            if (w >= 50) check("fill_wready", 32'(host_wready), 32'd1);
            host_wvalid = 1'b1;
            host_wdata  = base + 8'(i);
            tick();
            host_wvalid = 1'b0;
        end
    endtask

    task automatic claim(input logic wr);
        ctl_req = 1'b1; ctl_write = wr;
        tick();
        ctl_req = 1'b0; ctl_write = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ctl_ready !== 1'b1 && n < 50) begin tick(); n++; end
        check(name, 32'(ctl_ready), 32'd1);
    endtask

    task automatic done();
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        buff_addr = a; buff_rd = 1'b1;
        rd_q.push_back(exp);
        tick();
        buff_rd = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        buff_addr = a; buff_odata = d; buff_wr = 1'b1;
        tick();
        buff_wr = 1'b0;
    endtask

    task automatic write_sector(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), base + 8'(i));
            drain_q.push_back({i == 15, base + 8'(i)});
        end
    endtask

    task automatic wait_drain(input int target);
        int n;
        n = 0;
        while (drained < target && n < 200) begin tick(); n++; end
        check("drain_count", 32'(drained), 32'(target));
    endtask

    initial begin : stimulus
        int n;
        reset = 1'b1; buff_addr = '0; buff_rd = 1'b0; buff_wr = 1'b0; buff_odata = '0;
        ctl_req = 1'b0; ctl_write = 1'b0; ctl_done = 1'b0;
        host_load_en = 1'b0; host_flush = 1'b0; host_wvalid = 1'b0; host_wdata = '0;
        host_rready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_ctl_ready", 32'(ctl_ready), 32'd0);
        check("rst_host_bank", 32'(host_bank), 32'd0);
        check("rst_flush_busy", 32'(flush_busy), 32'd0);
        check("rst_wready", 32'(host_wready), 32'd0);
        check("rst_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_ctl_err", 32'(ctl_err), 32'd0);
        check("rst_idata", 32'(buff_idata), 32'd0);

        // Prefetch two sectors, then read them, second claim combined with release.
        host_load_en = 1'b1;
        fill(8'h00, 16);
        fill(8'h10, 16);
        host_load_en = 1'b0;
        check("load_hp_wrap", 32'(host_bank), 32'd0);
        check("load_wready_idle", 32'(host_wready), 32'd0);
        claim(1'b0);
        wait_ready("rd0_ready");
        rd(4'd5, 8'h05);
        rd(4'd0, 8'h00);
        rd(4'd15, 8'h0F);
        ctl_done = 1'b1; ctl_req = 1'b1;
        tick();
        ctl_done = 1'b0; ctl_req = 1'b0;
        check("done_req_release", 32'(ctl_ready), 32'd0);
        wait_ready("rd1_ready");
        rd(4'd5, 8'h15);
        rd(4'd15, 8'h1F);
        done();
        check("done_ready_low", 32'(ctl_ready), 32'd0);

        // Write sector and drain it with a 3-cycle host stall.
        claim(1'b1);
        wait_ready("wr_ready");
        write_sector(8'hA0);
        rd(4'd3, 8'hA3);
        done();
        host_rready = 1'b1;
        n = 0;
        while (drained < 5 && n < 50) begin tick(); n++; end
        host_rready = 1'b0;
        repeat (3) tick();
        check("stall_rvalid", 32'(host_rvalid), 32'd1);
        host_rready = 1'b1;
        wait_drain(16);
        host_rready = 1'b0;
        tick();
        check("store_hp", 32'(host_bank), 32'd1);
        check("store_rvalid_idle", 32'(host_rvalid), 32'd0);

        // Read claim on a FREE bank stalls until the host fills it.
        claim(1'b0);
        repeat (4) tick();
        check("stall_no_ready", 32'(ctl_ready), 32'd0);
        host_load_en = 1'b1;
        fill(8'h30, 16);
        host_load_en = 1'b0;
        check("stall_ready_at_ready", 32'(ctl_ready), 32'd0);
        tick();
        check("stall_ready_next", 32'(ctl_ready), 32'd1);
        rd(4'd9, 8'h39);
        done();

        // Flush waits for the pending drain, then frees prefetched banks.
        host_load_en = 1'b1;
        fill(8'h40, 16);
        fill(8'h50, 16);
        host_load_en = 1'b0;
        claim(1'b1);
        wait_ready("flush_wr_ready");
        write_sector(8'hB0);
        done();
        host_flush = 1'b1;
        tick();
        host_flush = 1'b0;
        repeat (5) tick();
        check("flush_busy_held", 32'(flush_busy), 32'd1);
        check("flush_rvalid", 32'(host_rvalid), 32'd1);
        host_rready = 1'b1;
        wait_drain(32);
        host_rready = 1'b0;
        n = 0;
        while (flush_busy !== 1'b0 && n < 20) begin tick(); n++; end
        check("flush_busy_drop", 32'(flush_busy), 32'd0);
        check("flush_hp_cp", 32'(host_bank), 32'd1);
        claim(1'b0);
        repeat (4) tick();
        check("flush_bank_free", 32'(ctl_ready), 32'd0);
        host_load_en = 1'b1;
        fill(8'h60, 16);
        host_load_en = 1'b0;
        wait_ready("flush_reload_ready");
        rd(4'd2, 8'h62);
        done();

        // Reset in the middle of a load aborts it and restarts counters.
        host_load_en = 1'b1;
        fill(8'h80, 7);
        n = 0;
        while (host_wready !== 1'b1 && n < 50) begin tick(); n++; end
        host_wvalid = 1'b1; host_wdata = 8'h87; reset = 1'b1; host_load_en = 1'b0;
        tick();
        host_wvalid = 1'b0; reset = 1'b0;
        check("midrst_wready", 32'(host_wready), 32'd0);
        check("midrst_hp", 32'(host_bank), 32'd0);
        check("midrst_ready", 32'(ctl_ready), 32'd0);
        host_load_en = 1'b1;
        fill(8'hC0, 16);
        host_load_en = 1'b0;
        claim(1'b0);
        wait_ready("midrst_claim");
        rd(4'd0, 8'hC0);
        rd(4'd7, 8'hC7);
        done();

        // Accesses without a held bank.
        wr(4'd4, 8'hEE);
        check("unheld_wr_err", 32'(ctl_err), 32'(GUARD));
        rd(4'd0, GUARD ? 8'hFF : 8'h60);
        claim(1'b1);
        check("err_cleared", 32'(ctl_err), 32'd0);
        wait_ready("guard_wr_ready");
        rd(4'd4, GUARD ? 8'h64 : 8'hEE);
        write_sector(8'hD0);
        done();
        host_rready = 1'b1;
        wait_drain(48);
        host_rready = 1'b0;
        check("final_ctl_err", 32'(ctl_err), 32'd0);

        repeat (3) tick();
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("drain_q_empty", 32'(drain_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
